// File: rtl/mips_pkg.sv
// Shared definitions for the MEM-stage data-memory interface.
//   - Memory operation size encodings used on e_MemRdOp / e_MemWrOp.
//   - MMIO register byte offsets relative to the MMIO window base.
//   - TCON bit positions.
//   - Helpers that turn an op + lane into a byte-enable mask, replicate
//     right-aligned store data across lanes, and extract/extend load lanes.
package mips_pkg;

    localparam logic [1:0] MEMOP_WORD = 2'b00;
    localparam logic [1:0] MEMOP_HALF = 2'b01;
    localparam logic [1:0] MEMOP_BYTE = 2'b11;
    localparam logic [1:0] MEMOP_NONE = 2'b10;

    localparam logic [7:0] MMIO_OFF_TH      = 8'h00;
    localparam logic [7:0] MMIO_OFF_TL      = 8'h04;
    localparam logic [7:0] MMIO_OFF_TCON    = 8'h08;
    localparam logic [7:0] MMIO_OFF_LEDS    = 8'h0C;
    localparam logic [7:0] MMIO_OFF_DIGITS  = 8'h10;
    localparam logic [7:0] MMIO_OFF_SYSTICK = 8'h14;

    localparam int TCON_W  = 3;
    localparam int TCON_EN = 0;  // timer enable
    localparam int TCON_IE = 1;  // interrupt enable
    localparam int TCON_IS = 2;  // interrupt status (sticky until CPU clears it)

    // Byte-lane write enables for a store of size op at byte lane.
    function automatic logic [3:0] store_mask(input logic [1:0] op, input logic [1:0] lane);
        logic [3:0] m;
        m = 4'b0000;
        case (op)
            MEMOP_WORD: m = 4'b1111;
            MEMOP_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            MEMOP_BYTE: m = 4'b0001 << lane;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data so every lane the mask can select
    // already carries the right bits.
    function automatic logic [31:0] store_lanes(input logic [1:0] op, input logic [31:0] data);
        logic [31:0] r;
        r = data;
        case (op)
            MEMOP_HALF: r = {2{data[15:0]}};
            MEMOP_BYTE: r = {4{data[7:0]}};
            default:    r = data;
        endcase
        return r;
    endfunction

    // Pull the addressed lane out of a word, move it to bit 0, then extend.
    function automatic logic [31:0] load_extend(input logic [1:0] op, input logic sext,
                                                input logic [1:0] lane, input logic [31:0] word);
        logic [31:0] r;
        logic [15:0] h;
        logic [7:0]  b;
        r = '0;
        h = lane[1] ? word[31:16] : word[15:0];
        b = word[8*lane +: 8];
        case (op)
            MEMOP_WORD: r = word;
            MEMOP_HALF: r = {{16{sext & h[15]}}, h};
            MEMOP_BYTE: r = {{24{sext & b[7]}}, b};
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Timer block of the MMIO window: TH reload value, TL counter, TCON control
// and a free-running systick.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   wr_th_i          word store to TH this cycle
//   wr_tl_i          word store to TL this cycle (beats the timer update)
//   wr_tcon_i        word store to TCON this cycle (beats the timer update)
//   wr_data_i        store data
//   th_o, tl_o       current TH / TL
//   tcon_o           current TCON[2:0]
//   systick_o        free-running cycle counter
//   irq_o            TCON status & TCON irq enable
module mmio_timer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_th_i,
    input  logic              wr_tl_i,
    input  logic              wr_tcon_i,
    input  logic [31:0]       wr_data_i,
    output logic [31:0]       th_o,
    output logic [31:0]       tl_o,
    output logic [TCON_W-1:0] tcon_o,
    output logic [31:0]       systick_o,
    output logic              irq_o
);

    logic [31:0]       th_q, th_d;
    logic [31:0]       tl_q, tl_d;
    logic [TCON_W-1:0] tcon_q, tcon_d;
    logic [31:0]       systick_q, systick_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        systick_d = systick_q + 32'd1;

        if (tcon_q[TCON_EN]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[TCON_IE]) begin
                    tcon_d[TCON_IS] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        // CPU stores are applied last so they override the timer update.
        if (wr_th_i) begin
            th_d = wr_data_i;
        end
        if (wr_tl_i) begin
            tl_d = wr_data_i;
        end
        if (wr_tcon_i) begin
            tcon_d = wr_data_i[TCON_W-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            systick_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
        end
    end

    assign th_o      = th_q;
    assign tl_o      = tl_q;
    assign tcon_o    = tcon_q;
    assign systick_o = systick_q;
    assign irq_o     = tcon_q[TCON_IS] & tcon_q[TCON_IE];

endmodule

// File: rtl/data_mem_bus.sv
// Responder end of the MEM-stage data-memory interface: a word-addressed RAM
// with byte/half/word lanes and sign/zero-extended loads, plus an MMIO window
// (timer, LEDs, 7-seg digits, systick). Loads are combinational; stores
// commit on the next rising clk edge.
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   e_MemRdOp     load size (00 word, 01 half, 11 byte, 10 none)
//   e_MemWrOp     store size (same encoding)
//   e_MemRdSign   1 = sign-extend sub-word loads
//   e_memAddr     byte address
//   e_memWData    right-aligned store data
//   e_memData     load data (0 when no load)
//   leds          LED register
//   digits        7-seg register ([11:8] anodes, [7:0] segments)
//   irq           timer interrupt request
module data_mem_bus
    import mips_pkg::*;
#(
    parameter int          RAM_AW    = 9,
    parameter logic [31:0] MMIO_BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  e_MemRdOp,
    input  logic [1:0]  e_MemWrOp,
    input  logic        e_MemRdSign,
    input  logic [31:0] e_memAddr,
    input  logic [31:0] e_memWData,
    output logic [31:0] e_memData,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    output logic        irq
);

    localparam int RAM_DEPTH = 2 ** RAM_AW;

    logic [31:0]       mem_q [RAM_DEPTH];
    logic [RAM_AW-1:0] ram_idx;
    logic              mmio_hit;
    logic              mmio_wr;
    logic [7:0]        mmio_off;
    logic [3:0]        ram_we;
    logic [31:0]       wr_lanes;
    logic [31:0]       rd_word;
    logic [31:0]       mmio_rdata;

    logic [7:0]        leds_q, leds_d;
    logic [11:0]       digits_q, digits_d;

    logic [31:0]       th, tl, systick;
    logic [TCON_W-1:0] tcon;

    // Decode. Out-of-range RAM addresses simply wrap on the index bits.
    assign mmio_hit = (e_memAddr[31:8] == MMIO_BASE[31:8]);
    assign ram_idx  = e_memAddr[RAM_AW+1:2];
    assign mmio_off = {e_memAddr[7:2], 2'b00};
    // MMIO only accepts full-word stores.
    assign mmio_wr  = mmio_hit && (e_MemWrOp == MEMOP_WORD);
    assign ram_we   = mmio_hit ? 4'b0000 : store_mask(e_MemWrOp, e_memAddr[1:0]);
    assign wr_lanes = store_lanes(e_MemWrOp, e_memWData);

    // NOTE: the RAM array has no reset; clearing every word would turn it
    // into a register file instead of an inferred memory.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) begin
                mem_q[ram_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_th_i   (mmio_wr && (mmio_off == MMIO_OFF_TH)),
        .wr_tl_i   (mmio_wr && (mmio_off == MMIO_OFF_TL)),
        .wr_tcon_i (mmio_wr && (mmio_off == MMIO_OFF_TCON)),
        .wr_data_i (e_memWData),
        .th_o      (th),
        .tl_o      (tl),
        .tcon_o    (tcon),
        .systick_o (systick),
        .irq_o     (irq)
    );

    always_comb begin
        leds_d   = leds_q;
        digits_d = digits_q;
        if (mmio_wr && (mmio_off == MMIO_OFF_LEDS)) begin
            leds_d = e_memWData[7:0];
        end
        if (mmio_wr && (mmio_off == MMIO_OFF_DIGITS)) begin
            digits_d = e_memWData[11:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q   <= '0;
            digits_q <= '0;
        end else begin
            leds_q   <= leds_d;
            digits_q <= digits_d;
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            MMIO_OFF_TH:      mmio_rdata = th;
            MMIO_OFF_TL:      mmio_rdata = tl;
            MMIO_OFF_TCON:    mmio_rdata = {{(32-TCON_W){1'b0}}, tcon};
            MMIO_OFF_LEDS:    mmio_rdata = {24'd0, leds_q};
            MMIO_OFF_DIGITS:  mmio_rdata = {20'd0, digits_q};
            MMIO_OFF_SYSTICK: mmio_rdata = systick;
            default:          mmio_rdata = '0;
        endcase
    end

    // Reading the array before the edge gives old data on a same-cycle
    // load + store to one address.
    assign rd_word   = mmio_hit ? mmio_rdata : mem_q[ram_idx];
    assign e_memData = load_extend(e_MemRdOp, e_MemRdSign, e_memAddr[1:0], rd_word);

    assign leds   = leds_q;
    assign digits = digits_q;

endmodule

// File: tb/tb_data_mem_bus.sv
// Directed self-checking bench for data_mem_bus.
module tb_data_mem_bus;
    import mips_pkg::*;

    localparam logic [31:0] MB = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  e_MemRdOp;
    logic [1:0]  e_MemWrOp;
    logic        e_MemRdSign;
    logic [31:0] e_memAddr;
    logic [31:0] e_memWData;
    logic [31:0] e_memData;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned tick_model;

    data_mem_bus dut (
        .clk         (clk),
        .reset       (reset),
        .e_MemRdOp   (e_MemRdOp),
        .e_MemWrOp   (e_MemWrOp),
        .e_MemRdSign (e_MemRdSign),
        .e_memAddr   (e_memAddr),
        .e_memWData  (e_memWData),
        .e_memData   (e_memData),
        .leds        (leds),
        .digits      (digits),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Expected systick: counts rising edges seen with reset low.
    always @(posedge clk or posedge reset) begin
        if (reset) tick_model <= 0;
        else       tick_model <= tick_model + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Store: drive, let one rising edge commit it, return 1 ns after the edge.
    task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        e_MemRdOp  = MEMOP_NONE;
        e_MemWrOp  = op;
        e_memAddr  = a;
        e_memWData = d;
        @(posedge clk);
        #1;
        e_MemWrOp  = MEMOP_NONE;
    endtask

    // Combinational load and check; takes 1 ns, never crosses a clock edge
    // when used a few times right after store().
    task automatic ld_chk(input string tag, input logic [1:0] op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] exp);
        e_MemWrOp   = MEMOP_NONE;
        e_MemRdOp   = op;
        e_MemRdSign = sgn;
        e_memAddr   = a;
        #1;
        check(tag, e_memData, exp);
    endtask

    initial begin
        reset       = 1'b1;
        e_MemRdOp   = MEMOP_NONE;
        e_MemWrOp   = MEMOP_NONE;
        e_MemRdSign = 1'b0;
        e_memAddr   = '0;
        e_memWData  = '0;

        // Reset state
        #12;
        check("rst_leds",   {24'd0, leds},   32'd0);
        check("rst_digits", {20'd0, digits}, 32'd0);
        check("rst_irq",    {31'd0, irq},    32'd0);
        ld_chk("rst_th",      MEMOP_WORD, 1'b0, MB + 32'h00, 32'd0);
        ld_chk("rst_tl",      MEMOP_WORD, 1'b0, MB + 32'h04, 32'd0);
        ld_chk("rst_tcon",    MEMOP_WORD, 1'b0, MB + 32'h08, 32'd0);
        ld_chk("rst_systick", MEMOP_WORD, 1'b0, MB + 32'h14, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1. word store, sign/zero byte loads
        store(MEMOP_WORD, 32'h10, 32'h8000_00FF);
        ld_chk("t1_lw",  MEMOP_WORD, 1'b0, 32'h10, 32'h8000_00FF);
        ld_chk("t1_lb",  MEMOP_BYTE, 1'b1, 32'h10, 32'hFFFF_FFFF);
        ld_chk("t1_lbu", MEMOP_BYTE, 1'b0, 32'h13, 32'h0000_0080);
        ld_chk("t1_lhu", MEMOP_HALF, 1'b0, 32'h12, 32'h0000_8000);

        // 2. half store over an existing word
        store(MEMOP_WORD, 32'h20, 32'h1122_3344);
        store(MEMOP_HALF, 32'h22, 32'h0000_BEEF);
        ld_chk("t2_lw",  MEMOP_WORD, 1'b0, 32'h20, 32'hBEEF_3344);
        ld_chk("t2_lh",  MEMOP_HALF, 1'b1, 32'h22, 32'hFFFF_BEEF);
        ld_chk("t2_lhu", MEMOP_HALF, 1'b0, 32'h21, 32'h0000_3344);
        ld_chk("t2_lb",  MEMOP_BYTE, 1'b1, 32'h21, 32'h0000_0033);

        // 3. byte store, same-cycle load+store, lane 3, address wrap
        store(MEMOP_WORD, 32'h04, 32'h1122_3344);
        store(MEMOP_BYTE, 32'h05, 32'hFFFF_FFAA);
        ld_chk("t3_sb", MEMOP_WORD, 1'b0, 32'h04, 32'h1122_AA44);
        e_MemRdOp  = MEMOP_WORD;
        e_MemWrOp  = MEMOP_WORD;
        e_memAddr  = 32'h04;
        e_memWData = 32'hCAFE_F00D;
        #1;
        check("t3_rw_old", e_memData, 32'h1122_AA44);
        @(posedge clk);
        #1;
        e_MemWrOp = MEMOP_NONE;
        #1;
        check("t3_rw_new", e_memData, 32'hCAFE_F00D);
        store(MEMOP_BYTE, 32'h07, 32'h0000_0080);
        ld_chk("t3_lb3", MEMOP_BYTE, 1'b1, 32'h07, 32'hFFFF_FF80);
        ld_chk("t3_lw3", MEMOP_WORD, 1'b0, 32'h04, 32'h80FE_F00D);
        store(MEMOP_WORD, 32'h00, 32'h1234_5678);
        ld_chk("t3_wrap", MEMOP_WORD, 1'b0, 32'h800, 32'h1234_5678);

        // 4. timer reload, irq, CPU priority
        store(MEMOP_WORD, MB + 32'h00, 32'hFFFF_FFFE);
        store(MEMOP_WORD, MB + 32'h04, 32'hFFFF_FFFE);
        store(MEMOP_WORD, MB + 32'h08, 32'd3);
        ld_chk("t4_tl0", MEMOP_WORD, 1'b0, MB + 32'h04, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        check("t4_irq1", {31'd0, irq}, 32'd0);
        ld_chk("t4_tl1", MEMOP_WORD, 1'b0, MB + 32'h04, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("t4_irq2", {31'd0, irq}, 32'd1);
        ld_chk("t4_tl2",   MEMOP_WORD, 1'b0, MB + 32'h04, 32'hFFFF_FFFE);
        ld_chk("t4_tcon2", MEMOP_WORD, 1'b0, MB + 32'h08, 32'd7);
        store(MEMOP_WORD, MB + 32'h08, 32'd3);
        check("t4_irq_clr", {31'd0, irq}, 32'd0);
        ld_chk("t4_tcon3", MEMOP_WORD, 1'b0, MB + 32'h08, 32'd3);
        @(posedge clk);
        #1;
        check("t4_irq_again", {31'd0, irq}, 32'd1);
        store(MEMOP_WORD, MB + 32'h08, 32'd0);
        ld_chk("t4_tl_stop", MEMOP_WORD, 1'b0, MB + 32'h04, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        ld_chk("t4_tl_frozen", MEMOP_WORD, 1'b0, MB + 32'h04, 32'hFFFF_FFFF);
        store(MEMOP_WORD, MB + 32'h08, 32'hFFFF_FFF9);
        ld_chk("t4_tcon_mask", MEMOP_WORD, 1'b0, MB + 32'h08, 32'd1);
        store(MEMOP_WORD, MB + 32'h04, 32'd5);
        ld_chk("t4_tl_cpu_wins", MEMOP_WORD, 1'b0, MB + 32'h04, 32'd5);
        @(posedge clk);
        #1;
        ld_chk("t4_tl_inc",   MEMOP_WORD, 1'b0, MB + 32'h04, 32'd6);
        ld_chk("t4_tcon_noie", MEMOP_WORD, 1'b0, MB + 32'h08, 32'd1);

        // 5. leds/digits, ignored MMIO stores, systick
        store(MEMOP_WORD, MB + 32'h0C, 32'h0000_005A);
        store(MEMOP_HALF, MB + 32'h0C, 32'h0000_1234);
        store(MEMOP_BYTE, MB + 32'h0C, 32'h0000_0077);
        check("t5_leds_port", {24'd0, leds}, 32'h0000_005A);
        ld_chk("t5_leds_lbu", MEMOP_BYTE, 1'b0, MB + 32'h0C, 32'h0000_005A);
        ld_chk("t5_leds_lb1", MEMOP_BYTE, 1'b1, MB + 32'h0D, 32'h0000_0000);
        store(MEMOP_WORD, MB + 32'h18, 32'hFFFF_FFFF);
        ld_chk("t5_off18", MEMOP_WORD, 1'b0, MB + 32'h18, 32'd0);
        store(MEMOP_WORD, MB + 32'h10, 32'hFFFF_FABC);
        check("t5_digits_port", {20'd0, digits}, 32'h0000_0ABC);
        ld_chk("t5_digits_lw", MEMOP_WORD, 1'b0, MB + 32'h10, 32'h0000_0ABC);
        ld_chk("t5_digits_lb", MEMOP_BYTE, 1'b1, MB + 32'h10, 32'hFFFF_FFBC);
        store(MEMOP_WORD, MB + 32'h14, 32'd0);
        ld_chk("t5_systick", MEMOP_WORD, 1'b0, MB + 32'h14, tick_model);

        // 6. async reset mid-run with the timer running and irq raised
        store(MEMOP_WORD, MB + 32'h08, 32'd7);
        check("t6_irq_pre", {31'd0, irq}, 32'd1);
        #2;
        reset      = 1'b1;
        e_MemWrOp  = MEMOP_WORD;
        e_memAddr  = MB + 32'h0C;
        e_memWData = 32'h0000_00FF;
        #1;
        check("t6_leds",   {24'd0, leds},   32'd0);
        check("t6_digits", {20'd0, digits}, 32'd0);
        check("t6_irq",    {31'd0, irq},    32'd0);
        e_MemRdOp = MEMOP_WORD;
        e_memAddr = MB + 32'h04;
        #1;
        check("t6_tl", e_memData, 32'd0);
        e_memAddr = MB + 32'h08;
        #1;
        check("t6_tcon", e_memData, 32'd0);
        e_memAddr = MB + 32'h14;
        #1;
        check("t6_systick", e_memData, 32'd0);
        e_memAddr = MB + 32'h0C;
        @(posedge clk);
        #1;
        check("t6_leds_nowrite", {24'd0, leds}, 32'd0);
        e_MemWrOp = MEMOP_NONE;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        ld_chk("t6_systick_run", MEMOP_WORD, 1'b0, MB + 32'h14, 32'd1);
        ld_chk("t6_tl_idle",     MEMOP_WORD, 1'b0, MB + 32'h04, 32'd0);
        ld_chk("t6_rd_none",     MEMOP_NONE, 1'b1, 32'h10,      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
